// File: rtl/pmu_i2c_sched_pkg.sv
// pmu_i2c_sched_pkg: shared state encoding, PMU address default and rw encodings for the scheduler
package pmu_i2c_sched_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_W_ADDR,
        S_W_SUB,
        S_W_DATA,
        S_R_STOP,
        S_R_ADDR,
        S_R_DATA,
        S_DONE,
        S_RESP
    } state_t;

    localparam logic [6:0] PMU_DEV_ADDR = 7'h34;
    localparam logic       RW_WRITE     = 1'b1;
    localparam logic       RW_READ      = 1'b0;

    // Index width that stays legal for a single requester
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pmu_i2c_sched_rr_arbiter.sv
// pmu_rr_arbiter: round-robin pick of the first pending request at or above the pointer, wrapping
module pmu_rr_arbiter
    import pmu_i2c_sched_pkg::*;
#(
    parameter int N = 3,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    int w_pos;

    // Walk N positions starting at the pointer; the first pending one wins
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_pos   = 0;
        for (int k = 0; k < N; k++) begin
            w_pos = (int'(i_ptr) + k) % N;
            if (!o_valid && i_req[w_pos]) begin
                o_valid       = 1'b1;
                o_gnt[w_pos]  = 1'b1;
                o_idx         = IW'(w_pos);
            end
        end
    end

endmodule

// File: rtl/pmu_i2c_sched.sv
// pmu_i2c_sched: round-robin sharing of one pmu_i2c byte engine for single-register PMU reads/writes
module pmu_i2c_sched
    import pmu_i2c_sched_pkg::*;
#(
    parameter int         NUM_REQ  = 3,
    parameter logic [6:0] DEV_ADDR = PMU_DEV_ADDR
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [NUM_REQ-1:0]   i_req_rd,
    input  logic [8*NUM_REQ-1:0] i_req_subaddr,
    input  logic [8*NUM_REQ-1:0] i_req_wdata,
    output logic [NUM_REQ-1:0]   o_ack,
    output logic                 o_ack_failed,
    output logic [7:0]           o_rdata,
    output logic                 o_busy,
    output logic [7:0]           o_i2c_data,
    output logic                 o_i2c_start,
    output logic                 o_i2c_done,
    output logic                 o_i2c_rw,
    output logic                 o_i2c_clear_failed,
    input  logic                 i_i2c_data_latch,
    input  logic                 i_i2c_ready,
    input  logic                 i_i2c_failed,
    input  logic [7:0]           i_i2c_in_data,
    input  logic                 i_i2c_in_data_valid
);

    localparam int IW = idx_width(NUM_REQ);

    state_t               r_state;
    logic [IW-1:0]        r_ptr;
    logic [IW-1:0]        r_idx;
    logic [NUM_REQ-1:0]   r_gnt;
    logic                 r_rd;
    logic [7:0]           r_sub;
    logic [7:0]           r_wdata;
    logic [NUM_REQ-1:0]   r_ack;
    logic                 r_ack_failed;
    logic [7:0]           r_rdata;
    logic                 r_busy;
    logic [7:0]           r_data;
    logic                 r_start;
    logic                 r_done;
    logic                 r_rw;
    logic                 r_clear;

    logic [NUM_REQ-1:0]   w_gnt;
    logic [IW-1:0]        w_idx;
    logic                 w_valid;

    pmu_rr_arbiter #(.N(NUM_REQ)) u_arb (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_gnt   (w_gnt),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    // Transaction sequencer; every output is set on the edge that enters the state it belongs to
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_idx        <= '0;
            r_gnt        <= '0;
            r_rd         <= 1'b0;
            r_sub        <= '0;
            r_wdata      <= '0;
            r_ack        <= '0;
            r_ack_failed <= 1'b0;
            r_rdata      <= '0;
            r_busy       <= 1'b0;
            r_data       <= '0;
            r_start      <= 1'b0;
            r_done       <= 1'b0;
            r_rw         <= RW_WRITE;
            r_clear      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_valid) begin
                    r_gnt   <= w_gnt;
                    r_idx   <= w_idx;
                    r_rd    <= i_req_rd[w_idx];
                    r_sub   <= i_req_subaddr[8*w_idx +: 8];
                    r_wdata <= i_req_wdata[8*w_idx +: 8];
                    r_busy  <= 1'b1;
                    r_data  <= {DEV_ADDR, 1'b0};
                    r_start <= 1'b1;
                    r_rw    <= RW_WRITE;
                    r_state <= S_W_ADDR;
                end
                S_W_ADDR: if (i_i2c_data_latch) begin
                    r_start <= 1'b0;
                    r_data  <= r_sub;
                    r_state <= S_W_SUB;
                end
                S_W_SUB: if (i_i2c_data_latch) begin
                    if (r_rd) begin
                        r_done  <= 1'b1;
                        r_state <= S_R_STOP;
                    end else begin
                        r_data  <= r_wdata;
                        r_state <= S_W_DATA;
                    end
                end
                S_W_DATA: if (i_i2c_data_latch) begin
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_R_STOP: if (i_i2c_ready) begin
                    r_done  <= 1'b0;
                    r_start <= 1'b1;
                    r_data  <= {DEV_ADDR, 1'b1};
                    r_state <= S_R_ADDR;
                end
                S_R_ADDR: if (i_i2c_data_latch) begin
                    r_start <= 1'b0;
                    r_rw    <= RW_READ;
                    r_state <= S_R_DATA;
                end
                S_R_DATA: begin
                    if (i_i2c_in_data_valid)
                        r_rdata <= i_i2c_in_data;
                    if (i_i2c_data_latch) begin
                        r_rw    <= RW_WRITE;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: if (i_i2c_ready) begin
                    r_done       <= 1'b0;
                    r_ack        <= r_gnt;
                    r_ack_failed <= i_i2c_failed;
                    r_clear      <= 1'b1;
                    r_busy       <= 1'b0;
                    r_ptr        <= (r_idx == IW'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    r_ack        <= '0;
                    r_ack_failed <= 1'b0;
                    r_clear      <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_ack              = r_ack;
    assign o_ack_failed       = r_ack_failed;
    assign o_rdata            = r_rdata;
    assign o_busy             = r_busy;
    assign o_i2c_data         = r_data;
    assign o_i2c_start        = r_start;
    assign o_i2c_done         = r_done;
    assign o_i2c_rw           = r_rw;
    assign o_i2c_clear_failed = r_clear;

endmodule

// File: tb/tb_pmu_i2c_sched.sv
// tb_pmu_i2c_sched: directed vectors against a behavioural pmu_i2c byte engine with NAK injection
module tb_pmu_i2c_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  i_req;
    logic [2:0]  i_req_rd;
    logic [23:0] i_req_subaddr;
    logic [23:0] i_req_wdata;
    logic [2:0]  o_ack;
    logic        o_ack_failed;
    logic [7:0]  o_rdata;
    logic        o_busy;
    logic [7:0]  o_i2c_data;
    logic        o_i2c_start;
    logic        o_i2c_done;
    logic        o_i2c_rw;
    logic        o_i2c_clear_failed;
    logic        i_i2c_data_latch;
    logic        i_i2c_ready;
    logic        i_i2c_failed;
    logic [7:0]  i_i2c_in_data;
    logic        i_i2c_in_data_valid;

    pmu_i2c_sched #(.NUM_REQ(3), .DEV_ADDR(7'h34)) dut (
        .clk                 (clk),
        .reset               (reset),
        .i_req               (i_req),
        .i_req_rd            (i_req_rd),
        .i_req_subaddr       (i_req_subaddr),
        .i_req_wdata         (i_req_wdata),
        .o_ack               (o_ack),
        .o_ack_failed        (o_ack_failed),
        .o_rdata             (o_rdata),
        .o_busy              (o_busy),
        .o_i2c_data          (o_i2c_data),
        .o_i2c_start         (o_i2c_start),
        .o_i2c_done          (o_i2c_done),
        .o_i2c_rw            (o_i2c_rw),
        .o_i2c_clear_failed  (o_i2c_clear_failed),
        .i_i2c_data_latch    (i_i2c_data_latch),
        .i_i2c_ready         (i_i2c_ready),
        .i_i2c_failed        (i_i2c_failed),
        .i_i2c_in_data       (i_i2c_in_data),
        .i_i2c_in_data_valid (i_i2c_in_data_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // engine model controls and byte log (9'h100 = stop, 9'h101 = read byte)
    int         m_nak  = -1;
    logic [7:0] m_rdat = 8'h00;
    int         m_cnt, m_rcnt, m_bytes;
    logic [8:0] q_log[$];

    int         q_ack[$];
    logic       q_fail[$];
    logic       q_clr[$];
    logic       q_busy[$];
    logic [7:0] q_rdat[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // behavioural pmu_i2c: latches each byte 2 cycles after it appears, ready 2 cycles into done
    initial begin
        i_i2c_data_latch = 0; i_i2c_ready = 0; i_i2c_failed = 0;
        i_i2c_in_data = 0; i_i2c_in_data_valid = 0;
        m_cnt = 0; m_rcnt = 0; m_bytes = 0;
        forever begin
            @(negedge clk);
            i_i2c_data_latch = 0; i_i2c_ready = 0; i_i2c_in_data_valid = 0;
            if (reset) begin
                m_cnt = 0; m_rcnt = 0; m_bytes = 0; i_i2c_failed = 0;
            end else begin
                if (o_i2c_clear_failed) i_i2c_failed = 0;
                if (!o_busy) m_bytes = 0;
                if (o_i2c_done) begin
                    m_rcnt++;
                    if (m_rcnt == 2) begin
                        i_i2c_ready = 1; m_rcnt = 0; q_log.push_back(9'h100);
                    end
                end else m_rcnt = 0;
                if (o_busy && !o_i2c_done) begin
                    m_cnt++;
                    if (m_cnt == 2) begin
                        m_cnt = 0; i_i2c_data_latch = 1;
                        if (o_i2c_rw) q_log.push_back({1'b0, o_i2c_data});
                        else begin
                            q_log.push_back(9'h101);
                            i_i2c_in_data = m_rdat; i_i2c_in_data_valid = 1;
                        end
                        if (m_bytes == m_nak) i_i2c_failed = 1;
                        m_bytes++;
                    end
                end else m_cnt = 0;
            end
        end
    end

    task automatic clear_q();
        q_log.delete(); q_ack.delete(); q_fail.delete();
        q_clr.delete(); q_busy.delete(); q_rdat.delete();
    endtask

    task automatic wait_acks(input int n, input logic [2:0] hold);
        int got = 0;
        for (int c = 0; c < 2000 && got < n; c++) begin
            @(negedge clk);
            if (|o_ack) begin
                for (int k = 0; k < 3; k++)
                    if (o_ack[k]) begin
                        q_ack.push_back(k);
                        if (!hold[k]) i_req[k] = 1'b0;
                    end
                q_fail.push_back(o_ack_failed); q_clr.push_back(o_i2c_clear_failed);
                q_busy.push_back(o_busy); q_rdat.push_back(o_rdata);
                got++;
            end
        end
        check("ack_count", got, n);
    endtask

    task automatic check_order(input string name, input int e0, input int e1, input int e2, input int n);
        int exp_o[3];
        exp_o = '{e0, e1, e2};
        check({name, "_size"}, q_ack.size(), n);
        for (int k = 0; k < n && k < q_ack.size(); k++)
            check($sformatf("%s_%0d", name, k), q_ack[k], exp_o[k]);
    endtask

    task automatic set_writes();
        for (int k = 0; k < 3; k++) begin
            i_req_rd[k] = 1'b0;
            i_req_subaddr[8*k +: 8] = 8'h20 + 8'(k);
            i_req_wdata[8*k +: 8]   = 8'h40 + 8'(k);
        end
    endtask

    typedef struct {
        int         idx;
        logic       rd;
        logic [7:0] sub;
        logic [7:0] wd;
        logic [7:0] mdat;
        int         nak;
        logic       fail;
        logic [7:0] rdat;
    } vec_t;

    vec_t       vt[6];
    logic [8:0] exp_log[$];
    int         seen, nacks;

    initial begin
        vt[0] = '{0, 1'b0, 8'h10, 8'h9A, 8'h00, -1, 1'b0, 8'h00};
        vt[1] = '{1, 1'b1, 8'h32, 8'h00, 8'h5C, -1, 1'b0, 8'h5C};
        vt[2] = '{2, 1'b0, 8'h55, 8'h01, 8'h00,  1, 1'b1, 8'h5C};
        vt[3] = '{0, 1'b1, 8'hFF, 8'h00, 8'hA3, -1, 1'b0, 8'hA3};
        vt[4] = '{1, 1'b1, 8'h00, 8'h00, 8'h7E,  2, 1'b1, 8'h7E};
        vt[5] = '{2, 1'b0, 8'h80, 8'hFF, 8'h00,  2, 1'b1, 8'h7E};

        reset = 1; i_req = 0; i_req_rd = 0; i_req_subaddr = 0; i_req_wdata = 0;
        repeat (3) @(negedge clk);
        check("rst_ack", o_ack, 0);
        check("rst_busy", o_busy, 0);
        check("rst_start", o_i2c_start, 0);
        check("rst_done", o_i2c_done, 0);
        check("rst_rw", o_i2c_rw, 1);
        check("rst_data", o_i2c_data, 0);
        check("rst_rdata", o_rdata, 0);
        reset = 0;
        @(negedge clk);

        // single transactions: writes, reads, NAKs on several bytes
        for (int v = 0; v < 6; v++) begin
            clear_q();
            m_nak = vt[v].nak; m_rdat = vt[v].mdat;
            i_req_rd[vt[v].idx] = vt[v].rd;
            i_req_subaddr[8*vt[v].idx +: 8] = vt[v].sub;
            i_req_wdata[8*vt[v].idx +: 8]   = vt[v].wd;
            i_req = 3'b001 << vt[v].idx;
            @(negedge clk);
            check($sformatf("v%0d_start_lat", v), {o_i2c_start, o_busy, o_i2c_data}, {2'b11, 8'h68});
            wait_acks(1, 3'b000);
            check($sformatf("v%0d_ack_idx", v), q_ack.size() > 0 ? q_ack[0] : -1, vt[v].idx);
            check($sformatf("v%0d_failed", v), q_fail.size() > 0 ? q_fail[0] : 1'bx, vt[v].fail);
            check($sformatf("v%0d_clear", v), q_clr.size() > 0 ? q_clr[0] : 1'bx, 1'b1);
            check($sformatf("v%0d_busy_resp", v), q_busy.size() > 0 ? q_busy[0] : 1'bx, 1'b0);
            check($sformatf("v%0d_rdata", v), q_rdat.size() > 0 ? q_rdat[0] : 8'hxx, vt[v].rdat);
            @(negedge clk);
            check($sformatf("v%0d_ack_pulse", v), {o_ack, o_i2c_clear_failed}, 0);
            if (!vt[v].rd) exp_log = '{9'h068, {1'b0, vt[v].sub}, {1'b0, vt[v].wd}, 9'h100};
            else           exp_log = '{9'h068, {1'b0, vt[v].sub}, 9'h100, 9'h069, 9'h101, 9'h100};
            check($sformatf("v%0d_log_len", v), q_log.size(), exp_log.size());
            for (int k = 0; k < exp_log.size() && k < q_log.size(); k++)
                check($sformatf("v%0d_log_%0d", v, k), q_log[k], exp_log[k]);
        end

        // simultaneous requests with pointer at 0, then 0 and 2
        clear_q(); m_nak = -1; set_writes();
        i_req = 3'b111;
        wait_acks(3, 3'b000);
        check_order("rr_all", 0, 1, 2, 3);
        check("rr_log_len", q_log.size(), 12);
        clear_q();
        i_req = 3'b101;
        wait_acks(2, 3'b000);
        check_order("rr_02", 0, 2, 0, 2);
        check("rdata_held", o_rdata, 8'h7E);

        // requester 0 keeps req high after its ack while 1 waits
        clear_q();
        i_req = 3'b011;
        wait_acks(3, 3'b001);
        i_req = 3'b000;
        check_order("hold0", 0, 1, 0, 3);

        // reset while the write data byte is on the bus
        clear_q();
        i_req_subaddr[15:8] = 8'h44; i_req_wdata[15:8] = 8'hC3;
        i_req = 3'b010;
        seen = 0;
        for (int c = 0; c < 200 && seen == 0; c++) begin
            @(negedge clk);
            if (o_busy && !o_i2c_done && o_i2c_data == 8'hC3) seen = 1;
        end
        check("reach_wdata", seen, 1);
        reset = 1; i_req = 3'b000;
        @(negedge clk);
        check("abort_outs", {o_ack, o_ack_failed, o_busy, o_i2c_start, o_i2c_done, o_i2c_clear_failed, o_i2c_rw},
              {3'b000, 5'b00000, 1'b1});
        check("abort_data", {o_i2c_data, o_rdata}, 16'h0000);
        reset = 0;
        nacks = 0;
        repeat (12) begin
            @(negedge clk);
            if (|o_ack) nacks++;
        end
        check("abort_no_ack", nacks, 0);
        clear_q();
        i_req = 3'b101;
        wait_acks(2, 3'b000);
        check_order("post_rst", 0, 2, 0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1);
    end

endmodule
